// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - LEGv8 fetch stage: PC, one-outstanding imem request, decode handoff, branch redirect
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [63:0] pc_out,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic [63:0] redirect_offset
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic [63:0] offset_bytes;
    logic [63:0] redirect_target;
    logic [63:0] pc_seq;

    // Offset is in words; the top two bits fall off and the sum wraps mod 2^64.
    assign offset_bytes    = redirect_offset << 2;
    assign redirect_target = redirect_pc + offset_bytes;
    assign pc_seq          = pc_q + 64'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            instr_q   <= 32'd0;
            pc_out_q  <= 64'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_req_ready) begin
                    state_d   = S_WAIT;
                    // A redirect racing the handshake leaves a stale fetch in flight.
                    discard_d = redirect;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_target;
                    if (imem_resp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_seq;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Gated by rst_n so the request drops the instant reset asserts.
    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = valid_q;
    assign instruction    = instr_q;
    assign pc_out         = pc_out_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the LEGv8 core. Holds the PC and requests 32-bit instruction words from instruction memory.
- Presents each fetched word with its PC to decode. The same word drives the immediate sign-extender downstream.
- Accepts branch redirects whose offset is the already sign-extended 64-bit word-offset immediate, and discards stale fetches on redirect.
- Supports one outstanding memory request at a time.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  64  fetch byte address; equals the current PC.
- imem_resp_valid  input  1  read data valid; arrives 1+ cycles after the request handshake.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instruction/pc_out valid toward decode.
- instr_ready  input  1  decode consumes the instruction this cycle.
- instruction  output  32  fetched word; feeds decode and the sign-extender.
- pc_out  output  64  address of the presented instruction.
- redirect  input  1  taken-branch pulse from execute.
- redirect_pc  input  64  PC of the taken branch.
- redirect_offset  input  64  sign-extended word offset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC; state=REQ; discard=0.
  - instr_valid=0, instruction=0, pc_out=0.
  - imem_req_valid=0 while rst_n is low.
- Redirect target = redirect_pc + (redirect_offset << 2), computed modulo 2^64.
- Sequential PC = pc + 4, also computed modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- State REQ:
  - imem_req_valid=1 and imem_addr=pc.
  - If imem_req_ready, go to WAIT.
  - The address is held stable until the handshake, except on redirect.
- State WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with discard=0: latch instruction=imem_rdata and pc_out=pc, set instr_valid=1, go to HOLD.
  - On imem_resp_valid with discard=1: drop the data, clear discard, go to REQ (pc already holds the redirect target).
- State HOLD:
  - instr_valid=1; outputs are held stable until instr_ready.
  - On instr_ready: instr_valid=0, pc=pc+4, go to REQ.
- Throughput: with ready=1 and a 1-cycle response, one instruction every 3 cycles.
- First request: imem_req_valid rises in the first cycle after rst_n deasserts.
- Redirect, by state (redirect overrides everything below):
  - REQ without handshake: pc=target next cycle; stay in REQ; the address changes.
  - REQ with handshake in the same cycle: pc=target, go to WAIT, discard=1.
  - WAIT: pc=target, discard=1. A response arriving in that same cycle is dropped, and the block goes straight to REQ.
  - HOLD: instr_valid=0 next cycle and the instruction is dropped even if instr_ready was high in the same cycle. pc=target; go to REQ.
  - A second redirect while discard=1 just overwrites pc; discard stays 1.
- imem_resp_valid outside WAIT is ignored.
- Reset mid-operation: all state returns to reset values immediately; the outstanding memory response is not tracked after reset.

Test Plan:
- Reset release, RESET_PC=0, ready=1, 1-cycle response, instr_ready=1 -> addresses 0x0,0x4,0x8 in successive REQ cycles; instr_valid every 3rd cycle; pc_out matches address.
- Decode stalls (instr_ready=0 for 5 cycles) while holding word 0xF8400020 at pc 0x8 -> instruction and pc_out stable, no new request; after ready, next address 0xC.
- Redirect in HOLD, redirect_pc=0x10, offset=0xFFFF_FFFF_FFFF_FFFE (-2) -> held instruction dropped, next imem_addr=0x8.
- Redirect in WAIT, redirect_pc=0x20, offset=0x3 -> late response discarded with no instr_valid; next request at 0x2C; its data is presented with pc_out=0x2C.
- Redirect coincident with the request handshake at pc 0x40 (redirect_pc 0x40, offset 0x10) -> response dropped; next request at 0x80.
- Redirect with redirect_pc 0xFFFF_FFFF_FFFF_FFF8 and offset 0x1 -> target 0xFFFF_FFFF_FFFF_FFFC; after that fetch, next address 0x0 (wrap).
- rst_n pulsed low mid-WAIT -> instr_valid=0 and imem_req_valid=0 immediately; fetch restarts at RESET_PC.
